// File: rtl/accel_apb_ctrl_pkg.sv
// accel_apb_ctrl_pkg: FSM states, register offsets and CTRL/STATUS bit positions shared by accel_apb_ctrl.
package accel_apb_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_DELAY   = 8'h08;
  localparam logic [7:0] OFF_TIMEOUT = 8'h0C;
  localparam logic [7:0] OFF_BASE    = 8'h10;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_STATE   = 4;
  localparam int ST_RD      = 16;
  localparam int ST_WR      = 24;
endpackage

// File: rtl/accel_ostd_counter.sv
// accel_ostd_counter: saturating up/down outstanding-transaction counter; sat_o flags a clamped step.
module accel_ostd_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         sat_o
);
  logic [W-1:0] count_q, count_d;
  logic up, dn, full, empty;
  assign up      = inc_i & ~dec_i;
  assign dn      = dec_i & ~inc_i;
  assign full    = &count_q;
  assign empty   = count_q == '0;
  assign sat_o   = ~clr_i & ((up & full) | (dn & empty));
  assign count_o = count_q;
  always_comb count_d = clr_i ? '0 : (up & ~full) ? count_q + W'(1) : (dn & ~empty) ? count_q - W'(1) : count_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/accel_apb_ctrl.sv
// accel_apb_ctrl: APB control/status for an AXI-master accelerator (reset sequencer, address windows,
// outstanding tracking, done irq); define ACCEL_APB_CTRL_WATCHDOG_EN to add the TIMEOUT watchdog.
module accel_apb_ctrl #(
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_WIN         = 4,
  parameter int CNT_WIDTH       = 8,
  parameter int RESET_DELAY_DEF = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  core_reset,
  output logic                  core_clk_en,
  input  logic                  core_busy,
  input  logic [ADDR_WIDTH-1:0] araddr_raw,
  input  logic [ADDR_WIDTH-1:0] awaddr_raw,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  input  logic                  bvalid,
  input  logic                  bready,
  output logic                  irq
);
  import accel_apb_ctrl_pkg::*;
  localparam int WIN_SEL_BITS = $clog2(NUM_WIN);
  state_e state_q, state_d;
  logic [15:0] dly_q, dcnt_q, dcnt_d;
  logic [ADDR_WIDTH-1:0] base_q [NUM_WIN];
  logic [31:0] prdata_q, rdata, to_val;
  logic [CNT_WIDTH-1:0] rd_cnt, wr_cnt;
  logic [7:0] off;
  logic busy_seen_q, busy_seen_d, done_q, ovf_q, irq_q;
  logic wr_en, w_stat, hit_base, hit_to, base_lock, mapped, busy, start, abort, enter_done, wd_fire, err, clr;
  logic rd_sat, wr_sat, unused_paddr;
  assign off          = paddr[7:0];
  assign unused_paddr = ^paddr[31:8];
  assign wr_en        = psel & penable & pwrite;
  assign w_stat       = wr_en && off == OFF_STATUS;
  assign start        = wr_en && off == OFF_CTRL && pwdata[CTRL_START];
  assign abort        = wr_en && off == OFF_CTRL && pwdata[CTRL_ABORT];
  assign base_lock    = state_q inside {S_RESET, S_RUN, S_DRAIN};
  assign busy         = state_q != S_IDLE && state_q != S_DONE;
  assign mapped       = hit_base | hit_to | off == OFF_CTRL | off == OFF_STATUS | off == OFF_DELAY;
  assign pready       = 1'b1;
  assign pslverr      = psel & penable & (~mapped | (pwrite & hit_base & base_lock));
  assign prdata       = prdata_q;
  assign irq          = irq_q;
  assign core_reset   = state_q inside {S_IDLE, S_RESET};
  assign core_clk_en  = state_q inside {S_RESET, S_RUN, S_DRAIN};
  assign clr          = abort | wd_fire;
  assign enter_done   = state_q == S_DRAIN && state_d == S_DONE;
  always_comb begin
    hit_base = 1'b0;
    rdata    = '0;
    for (int i = 0; i < NUM_WIN; i++)
      if (off == 8'(OFF_BASE + 4 * i)) begin
        hit_base = 1'b1;
        rdata    = 32'(base_q[i]);
      end
    if (off == OFF_DELAY) rdata = {16'd0, dly_q};
    if (hit_to) rdata = to_val;
    if (off == OFF_STATUS) begin
      rdata[ST_BUSY]       = busy;
      rdata[ST_DONE]       = done_q;
      rdata[ST_OVF]        = ovf_q;
      rdata[ST_ERR]        = err;
      rdata[ST_STATE +: 3] = state_q;
      rdata[ST_RD +: 8]    = 8'(rd_cnt);
      rdata[ST_WR +: 8]    = 8'(wr_cnt);
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_RESET : state_q;
      S_RESET:        state_d = (dcnt_q + 16'd1 >= dly_q) ? S_RUN : S_RESET;
      S_RUN:          state_d = (busy_seen_q && !core_busy) ? S_DRAIN : S_RUN;
      S_DRAIN:        state_d = (rd_cnt == '0 && wr_cnt == '0) ? S_DONE : S_DRAIN;
      default:        state_d = S_IDLE;
    endcase
    if (wd_fire || abort) state_d = S_IDLE;
  end
  assign dcnt_d      = (state_q == S_RESET && state_d == S_RESET) ? dcnt_q + 16'd1 : '0;
  assign busy_seen_d = state_q == S_RUN && state_d == S_RUN && (busy_seen_q || core_busy);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      dly_q       <= 16'(RESET_DELAY_DEF);
      busy_seen_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      prdata_q    <= '0;
      for (int i = 0; i < NUM_WIN; i++) base_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      busy_seen_q <= busy_seen_d;
      irq_q       <= enter_done | (wd_fire & ~abort);
      done_q      <= enter_done | (done_q & ~(w_stat & pwdata[ST_DONE]));
      ovf_q       <= rd_sat | wr_sat | (ovf_q & ~(w_stat & pwdata[ST_OVF]));
      if (psel && !penable && !pwrite) prdata_q <= rdata;
      if (wr_en && off == OFF_DELAY) dly_q <= pwdata[15:0];
      for (int i = 0; i < NUM_WIN; i++)
        if (wr_en && !base_lock && off == 8'(OFF_BASE + 4 * i)) base_q[i] <= ADDR_WIDTH'(pwdata);
    end
`ifdef ACCEL_APB_CTRL_WATCHDOG_EN
  logic [31:0] to_q, wd_q;
  logic err_q, in_run;
  assign in_run  = state_q == S_RUN || state_q == S_DRAIN;
  assign hit_to  = off == OFF_TIMEOUT;
  assign to_val  = to_q;
  assign err     = err_q;
  assign wd_fire = in_run && to_q != '0 && wd_q + 32'd1 >= to_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      to_q  <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_en && hit_to) to_q <= pwdata;
      wd_q  <= in_run ? wd_q + 32'd1 : '0;
      err_q <= (wd_fire & ~abort) | (err_q & ~(w_stat & pwdata[ST_ERR]));
    end
`else
  assign hit_to  = 1'b0;
  assign to_val  = '0;
  assign err     = 1'b0;
  assign wd_fire = 1'b0;
`endif
  if (NUM_WIN == 1) begin : g_one
    assign araddr = base_q[0] + araddr_raw;
    assign awaddr = base_q[0] + awaddr_raw;
  end else begin : g_win
    localparam logic [ADDR_WIDTH-1:0] LOW = {ADDR_WIDTH{1'b1}} >> WIN_SEL_BITS;
    assign araddr = base_q[araddr_raw[ADDR_WIDTH-1 -: WIN_SEL_BITS]] + (araddr_raw & LOW);
    assign awaddr = base_q[awaddr_raw[ADDR_WIDTH-1 -: WIN_SEL_BITS]] + (awaddr_raw & LOW);
  end
  accel_ostd_counter #(.W(CNT_WIDTH)) u_rd (
    .clk(clk), .reset(reset), .inc_i(arvalid & arready), .dec_i(rvalid & rready & rlast),
    .clr_i(clr), .count_o(rd_cnt), .sat_o(rd_sat)
  );
  accel_ostd_counter #(.W(CNT_WIDTH)) u_wr (
    .clk(clk), .reset(reset), .inc_i(awvalid & awready), .dec_i(bvalid & bready),
    .clr_i(clr), .count_o(wr_cnt), .sat_o(wr_sat)
  );
endmodule

// File: tb/tb_accel_apb_ctrl.sv
// tb_accel_apb_ctrl: directed and randomized self-checking bench for accel_apb_ctrl (default parameters).
module tb_accel_apb_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic pready, pslverr, core_reset, core_clk_en, irq;
  logic core_busy = 1'b0;
  logic [31:0] araddr_raw = '0, awaddr_raw = '0, araddr, awaddr;
  logic arvalid = 0, arready = 0, awvalid = 0, awready = 0, rvalid = 0, rready = 0, rlast = 0, bvalid = 0, bready = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  accel_apb_ctrl dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr), .core_reset(core_reset),
    .core_clk_en(core_clk_en), .core_busy(core_busy), .araddr_raw(araddr_raw), .awaddr_raw(awaddr_raw),
    .araddr(araddr), .awaddr(awaddr), .arvalid(arvalid), .arready(arready), .awvalid(awvalid),
    .awready(awready), .rvalid(rvalid), .rready(rready), .rlast(rlast), .bvalid(bvalid), .bready(bready),
    .irq(irq)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
    psel = 1; pwrite = 1; penable = 0; paddr = 32'(a); pwdata = d;
    tick();
    penable = 1;
    #1 err = pslverr;
    tick();
    psel = 0; penable = 0; pwrite = 0;
  endtask
  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
    psel = 1; pwrite = 0; penable = 0; paddr = 32'(a);
    tick();
    penable = 1;
    #1 d = prdata; err = pslverr;
    tick();
    psel = 0; penable = 0;
  endtask
  task automatic axi_idle();
    {arvalid, arready, awvalid, awready, rvalid, rready, rlast, bvalid, bready} = '0;
  endtask
  initial begin
    logic [31:0] v, exp_a, exp_w;
    logic e;
    int n, rd_m, wr_m;
    bit ovf_m, ai, rdd, wi, wd;
    logic [31:0] base_m [4];
    for (int i = 0; i < 4; i++) base_m[i] = '0;
    #1 reset = 0;
    #2;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_clk_en", core_clk_en, 0);
    chk("rst_irq", irq, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pready", pready, 1);
    tick(); tick();
    reset = 1;
    tick();
    apb_rd(8'h08, v, e); chk("delay_default", v, 12);
    apb_rd(8'h10, v, e); chk("base0_default", v, 0);
    apb_rd(8'h04, v, e); chk("status_idle", v, 0);
    apb_wr(8'h14, 32'h8000_0000, e); base_m[1] = 32'h8000_0000;
    chk("base1_wr_err", e, 0);
    araddr_raw = 32'h4000_0010; #1;
    chk("xlate_spec", araddr, 32'h8000_0010);
    apb_wr(8'h1C, 32'hFFFF_FFF0, e); base_m[3] = 32'hFFFF_FFF0;
    awaddr_raw = 32'hC000_0020; #1;
    chk("xlate_wrap", awaddr, 32'h0000_0010);
    for (int i = 0; i < 4; i++) begin
      base_m[i] = $urandom;
      apb_wr(8'(16 + 4 * i), base_m[i], e);
    end
    for (int k = 0; k < 12; k++) begin
      araddr_raw = $urandom; awaddr_raw = $urandom; #1;
      exp_a = base_m[araddr_raw / 32'h4000_0000] + araddr_raw % 32'h4000_0000;
      exp_w = base_m[awaddr_raw / 32'h4000_0000] + awaddr_raw % 32'h4000_0000;
      chk("xlate_rand_ar", araddr, exp_a);
      chk("xlate_rand_aw", awaddr, exp_w);
    end
    apb_wr(8'h08, 32'd5, e);
    apb_wr(8'h00, 32'd1, e);
    n = 0;
    while (core_reset && core_clk_en && n < 20) begin n++; tick(); end
    chk("reset_len_5", n, 5);
    chk("run_core_reset", core_reset, 0);
    chk("run_clk_en", core_clk_en, 1);
    apb_wr(8'h14, 32'h1234_5678, e);
    chk("base_wr_in_run_err", e, 1);
    apb_rd(8'h14, v, e); chk("base_unchanged", v, base_m[1]);
    apb_rd(8'h04, v, e); chk("status_run", v[6:0], 7'h21);
    arvalid = 1; arready = 1; core_busy = 1;
    repeat (3) tick();
    axi_idle(); core_busy = 0;
    tick();
    rvalid = 1; rready = 1; rlast = 1;
    repeat (2) tick();
    axi_idle();
    apb_rd(8'h04, v, e);
    chk("drain_state", v[6:4], 3);
    chk("drain_rd_cnt", v[23:16], 1);
    rvalid = 1; rready = 1; rlast = 1;
    tick();
    axi_idle();
    chk("drain_no_irq_yet", irq, 0);
    tick();
    chk("done_irq", irq, 1);
    chk("done_clk_en", core_clk_en, 0);
    chk("done_core_reset", core_reset, 0);
    tick();
    chk("done_irq_1cyc", irq, 0);
    apb_rd(8'h04, v, e); chk("status_done", v[6:0], 7'h42);
    apb_wr(8'h04, 32'h2, e);
    apb_rd(8'h04, v, e); chk("done_w1c", v[1], 0);
    apb_wr(8'h08, 32'd0, e);
    apb_wr(8'h00, 32'd1, e);
    n = 0;
    while (core_reset && core_clk_en && n < 20) begin n++; tick(); end
    chk("reset_len_0", n, 1);
    arvalid = 1; arready = 1;
    repeat (2) tick();
    rvalid = 1; rready = 1; rlast = 1;
    tick();
    axi_idle();
    apb_rd(8'h04, v, e);
    chk("simul_cnt", v[23:16], 2);
    chk("simul_no_ovf", v[2], 0);
    apb_wr(8'h00, 32'd3, e);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_clk_en", core_clk_en, 0);
    chk("abort_no_irq", irq, 0);
    tick();
    chk("abort_no_irq2", irq, 0);
    apb_rd(8'h04, v, e);
    chk("abort_state", v[6:4], 0);
    chk("abort_cnt_clr", v[23:16], 0);
    arvalid = 1; arready = 1;
    repeat (255) tick();
    axi_idle();
    apb_rd(8'h04, v, e);
    chk("cnt_255", v[23:16], 255);
    chk("no_ovf_at_255", v[2], 0);
    arvalid = 1; arready = 1;
    tick();
    axi_idle();
    apb_rd(8'h04, v, e);
    chk("cnt_sat_255", v[23:16], 255);
    chk("ovf_set", v[2], 1);
    apb_wr(8'h04, 32'h4, e);
    apb_rd(8'h04, v, e); chk("ovf_w1c", v[2], 0);
    apb_wr(8'h00, 32'd2, e);
    bvalid = 1; bready = 1;
    tick();
    axi_idle();
    apb_rd(8'h04, v, e);
    chk("wr_underflow_cnt", v[31:24], 0);
    chk("wr_underflow_ovf", v[2], 1);
    apb_wr(8'h04, 32'h4, e);
    rd_m = 0; wr_m = 0; ovf_m = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 40; c++) begin
        arvalid = ($urandom_range(0, 99) < 80); arready = ($urandom_range(0, 99) < 80);
        rvalid = ($urandom_range(0, 99) < 50); rready = ($urandom_range(0, 99) < 70); rlast = $urandom_range(0, 1);
        awvalid = ($urandom_range(0, 99) < 40); awready = ($urandom_range(0, 99) < 70);
        bvalid = ($urandom_range(0, 99) < 60); bready = ($urandom_range(0, 99) < 80);
        ai = arvalid && arready; rdd = rvalid && rready && rlast;
        wi = awvalid && awready; wd = bvalid && bready;
        if (ai && !rdd) begin if (rd_m == 255) ovf_m = 1; else rd_m++; end
        else if (rdd && !ai) begin if (rd_m == 0) ovf_m = 1; else rd_m--; end
        if (wi && !wd) begin if (wr_m == 255) ovf_m = 1; else wr_m++; end
        else if (wd && !wi) begin if (wr_m == 0) ovf_m = 1; else wr_m--; end
        tick();
      end
      axi_idle();
      apb_rd(8'h04, v, e);
      chk("rand_rd_cnt", v[23:16], rd_m);
      chk("rand_wr_cnt", v[31:24], wr_m);
      chk("rand_ovf", v[2], ovf_m);
      apb_wr(8'h04, 32'h4, e); ovf_m = 0;
    end
    apb_wr(8'h00, 32'd2, e);
    apb_rd(8'h20, v, e); chk("unmapped_0x20", e, 1);
    apb_rd(8'h06, v, e); chk("unmapped_0x06", e, 1);
    apb_rd(8'h00, v, e); chk("ctrl_read_ok", e, 0);
`ifdef ACCEL_APB_CTRL_WATCHDOG_EN
    apb_wr(8'h0C, 32'd100, e); chk("timeout_wr_ok", e, 0);
    apb_rd(8'h0C, v, e); chk("timeout_rd", v, 100);
    apb_wr(8'h08, 32'd1, e);
    apb_wr(8'h00, 32'd1, e);
    core_busy = 1;
    n = 0;
    while (core_reset && n < 50) begin n++; tick(); end
    chk("wd_in_run", core_reset, 0);
    n = 0;
    while (!irq && n < 300) begin n++; tick(); end
    chk("wd_irq_delay", n, 100);
    chk("wd_core_reset", core_reset, 1);
    core_busy = 0;
    apb_rd(8'h04, v, e);
    chk("wd_err", v[3], 1);
    chk("wd_state_idle", v[6:4], 0);
    apb_wr(8'h04, 32'h8, e);
    apb_rd(8'h04, v, e); chk("wd_err_w1c", v[3], 0);
    apb_wr(8'h0C, 32'd0, e);
`else
    apb_rd(8'h0C, v, e); chk("timeout_unmapped", e, 1);
    apb_rd(8'h04, v, e); chk("err_reads_0", v[3], 0);
`endif
    apb_wr(8'h08, 32'd10, e);
    apb_wr(8'h00, 32'd1, e);
    tick();
    apb_rd(8'h08, v, e); chk("delay_rd_in_reset", v, 10);
    chk("mid_reset_state", core_clk_en, 1);
    #2 reset = 0;
    #1;
    chk("async_core_reset", core_reset, 1);
    chk("async_clk_en", core_clk_en, 0);
    chk("async_irq", irq, 0);
    chk("async_prdata", prdata, 0);
    tick(); tick();
    reset = 1;
    tick();
    apb_rd(8'h08, v, e); chk("delay_after_reset", v, 12);
    apb_rd(8'h04, v, e); chk("state_after_reset", v[6:4], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
